// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg -- shared types for the register-file writeback arbiter:
// priority-state enum, writeback request struct and small helpers.
`ifndef DATA_SIZE_MAX
`include "define.sv"
`endif

package rf_wb_arbiter_pkg;

   localparam int DATA_SIZE = `DATA_SIZE_MAX;
   localparam int ADDR_W    = 5;

   typedef enum logic {
      PRI_ALU = 1'b0,
      PRI_LSU = 1'b1
   } pri_state_t;

   typedef struct packed {
      logic                 valid;
      logic [ADDR_W-1:0]    addr;
      logic [DATA_SIZE-1:0] data;
   } wb_req_t;

   // A starvation limit below one is meaningless; clamp it to one.
   function automatic int eff_limit(input int limit);
      return (limit < 1) ? 1 : limit;
   endfunction

   // Register 0 is hard-wired, so an accepted write to it never reaches the file.
   function automatic logic writes_rf(input wb_req_t req);
      return req.valid && (req.addr != 5'd0);
   endfunction

endpackage

// File: rtl/define.sv
// define.sv -- global datapath width shared by the register-file writeback path.
`ifndef DATA_SIZE_MAX
`define DATA_SIZE_MAX 32
`endif

// File: rtl/rf_wb_prio_fsm.sv
// rf_wb_prio_fsm -- starvation counter and priority FSM for the writeback arbiter.
// Optional feature macro: RF_WB_STARVE_GUARD_EN. When undefined the arbiter runs
// strict ALU priority and pri_state is tied to PRI_ALU.
module rf_wb_prio_fsm
   import rf_wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic req1_valid,
   input  logic req1_ready,
   output logic pri_state
);

   localparam int              LIMIT   = eff_limit(STARVE_LIMIT);
   localparam int              CNT_W   = $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

`ifdef RF_WB_STARVE_GUARD_EN

   pri_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;

   // Count blocked req1 cycles; hand priority to req1 once starved, return it on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= PRI_ALU;
         cnt_r   <= '0;
      end else if (stall) begin
         state_r <= state_r;
         cnt_r   <= cnt_r;
      end else begin
         case (state_r)
            PRI_ALU: begin
               if (req1_valid && req1_ready) begin
                  state_r <= PRI_ALU;
                  cnt_r   <= '0;
               end else if (req1_valid) begin
                  if (cnt_r >= (CNT_MAX - 1'b1)) begin
                     state_r <= PRI_LSU;
                     cnt_r   <= CNT_MAX;
                  end else begin
                     state_r <= PRI_ALU;
                     cnt_r   <= cnt_r + 1'b1;
                  end
               end else begin
                  state_r <= PRI_ALU;
                  cnt_r   <= cnt_r;
               end
            end
            PRI_LSU: begin
               if (req1_valid && req1_ready) begin
                  state_r <= PRI_ALU;
                  cnt_r   <= '0;
               end else begin
                  state_r <= PRI_LSU;
                  cnt_r   <= cnt_r;
               end
            end
            default: begin
               state_r <= PRI_ALU;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign pri_state = state_r;

`else

   // Strict ALU priority: no counter, priority never moves.
   assign pri_state = PRI_ALU;

   logic unused_s;
   assign unused_s = ^{clk, rst, stall, req1_valid, req1_ready, CNT_MAX};

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter -- arbitrates ALU (req0) and load/long-latency (req1) writebacks
// onto a single registered register-file write port.
// Optional feature macro: RF_WB_STARVE_GUARD_EN enables the req1 starvation guard.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Istall,
   input  logic                 Dstall,
   input  logic                 req0_valid,
   input  logic [4:0]           req0_addr,
   input  logic [DATA_SIZE-1:0] req0_data,
   output logic                 req0_ready,
   input  logic                 req1_valid,
   input  logic [4:0]           req1_addr,
   input  logic [DATA_SIZE-1:0] req1_data,
   output logic                 req1_ready,
   output logic                 RF_write,
   output logic [4:0]           write_addr,
   output logic [DATA_SIZE-1:0] write_data,
   output logic                 pri_state
);

   logic    stall_s;
   logic    gnt0_s;
   logic    gnt1_s;
   logic    pri_s;
   wb_req_t req0_s;
   wb_req_t req1_s;
   wb_req_t sel_s;

   assign stall_s = Istall | Dstall;
   assign req0_s  = '{valid: req0_valid, addr: req0_addr, data: req0_data};
   assign req1_s  = '{valid: req1_valid, addr: req1_addr, data: req1_data};

   rf_wb_prio_fsm #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio_fsm (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall_s),
      .req1_valid (req1_valid),
      .req1_ready (gnt1_s),
      .pri_state  (pri_s)
   );

   // Grant: nothing during reset or stall, sole requester always wins, priority breaks ties.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (rst || stall_s) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (req0_s.valid && req1_s.valid) begin
         if (pri_s == PRI_LSU) begin
            gnt1_s = 1'b1;
         end else begin
            gnt0_s = 1'b1;
         end
      end else begin
         gnt0_s = req0_s.valid;
         gnt1_s = req1_s.valid;
      end
   end

   // Route the granted request toward the write port; valid is clear when nothing is accepted.
   always_comb begin
      sel_s = '0;
      if (gnt1_s) begin
         sel_s = req1_s;
      end else if (gnt0_s) begin
         sel_s = req0_s;
      end else begin
         sel_s = '0;
      end
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;
   assign pri_state  = pri_s;

   // Register the accepted write one cycle later; hold everything while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RF_write   <= 1'b0;
         write_addr <= 5'd0;
         write_data <= '0;
      end else if (stall_s) begin
         RF_write   <= RF_write;
         write_addr <= write_addr;
         write_data <= write_data;
      end else if (sel_s.valid) begin
         RF_write   <= writes_rf(sel_s);
         write_addr <= sel_s.addr;
         write_data <= sel_s.data;
      end else begin
         RF_write   <= 1'b0;
         write_addr <= write_addr;
         write_data <= write_data;
      end
   end

endmodule
